dm_unit: RTL and testbench

Data-memory stage for the pipelined RISC-V core: it consumes the MEM-stage request the CPU drives (address, store data, write strobe, access type) and returns load data to the MEM/WB path in the same cycle. It sits directly downstream of the CPU inside the computer top level, replacing the bare word-array data memory. It adds sub-word store merging, load sign/zero extension, misalignment detection with sticky status, and an optional memory-mapped I/O window.

---
 rtl/dm_pkg.sv | 37 +++
 rtl/dm_lane_align.sv | 49 ++++
 rtl/dm_unit.sv | 165 ++++++++++++++++
 tb/tb_dm_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory stage.
//   - dm_type_e  : access-type codes driven by the CPU MEM stage
//   - MMIO_OFF_* : word offsets (addr[3:2]) inside the MMIO window
//   - is_half / is_byte / is_misaligned : access-size and alignment helpers
// Codes outside the enumerated set are treated as full-word accesses.
package dm_pkg;

    typedef enum logic [2:0] {
        DM_WORD   = 3'b000,
        DM_HALF   = 3'b001,
        DM_HALF_U = 3'b010,
        DM_BYTE   = 3'b011,
        DM_BYTE_U = 3'b100
    } dm_type_e;

    localparam logic [1:0] MMIO_OFF_OUT    = 2'd0;
    localparam logic [1:0] MMIO_OFF_CYCLE  = 2'd1;
    localparam logic [1:0] MMIO_OFF_STATUS = 2'd2;
    localparam logic [1:0] MMIO_OFF_RSVD   = 2'd3;

    function automatic logic is_half(input logic [2:0] t);
        return (t == DM_HALF) || (t == DM_HALF_U);
    endfunction

    function automatic logic is_byte(input logic [2:0] t);
        return (t == DM_BYTE) || (t == DM_BYTE_U);
    endfunction

    // Bytes are never misaligned; halves need addr[0]=0; everything else
    // (word and the unused codes) needs addr[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] a);
        if (is_byte(t)) return 1'b0;
        if (is_half(t)) return a[0];
        return (a != 2'b00);
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: purely combinational lane steering.
//   addr_lo  in  2   byte offset within the word
//   dm_type  in  3   access type
//   st_data  in  32  right-aligned store data
//   ld_word  in  32  raw 32-bit word read from the selected target
//   st_be    out 4   byte enables for the store
//   st_word  out 32  store data replicated into every lane (only enabled
//                    lanes are consumed, so replication equals a shift)
//   ld_data  out 32  extracted and sign/zero-extended load data
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  dm_type,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  st_be,
    output logic [31:0] st_word,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        st_be   = 4'b1111;
        st_word = st_data;
        if (is_byte(dm_type)) begin
            st_be   = 4'b0001 << addr_lo;
            st_word = {4{st_data[7:0]}};
        end else if (is_half(dm_type)) begin
            st_be   = addr_lo[1] ? 4'b1100 : 4'b0011;
            st_word = {2{st_data[15:0]}};
        end
    end

    always_comb begin
        byte_sel = ld_word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (dm_type)
            DM_HALF:   ld_data = {{16{half_sel[15]}}, half_sel};
            DM_HALF_U: ld_data = {16'h0000, half_sel};
            DM_BYTE:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            DM_BYTE_U: ld_data = {24'h000000, byte_sel};
            default:   ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dm_unit.sv
// dm_unit: data-memory stage for the pipelined RISC-V core.
// Sub-word stores, sign/zero-extended loads (zero latency), misalignment
// detection with a sticky flag, first-error address and saturating count,
// and a free-running cycle counter.
// Optional build macro DM_MMIO_EN: addresses with addr[31:4]==MMIO_BASE[31:4]
// decode to an MMIO window (OUT / CYCLE / STATUS / reserved) instead of RAM.
// Ports:
//   clk           in  1   rising-edge clock
//   rstn          in  1   asynchronous active-low reset (RAM not reset)
//   mem_w         in  1   store strobe
//   addr          in  32  byte address
//   din           in  32  right-aligned store data
//   dm_type       in  3   access type (see dm_pkg)
//   dout          out 32  extended load data, combinational
//   mmio_out      out 32  MMIO OUT register (0 when MMIO disabled)
//   misalign_err  out 1   sticky misalignment flag
//   err_addr      out 32  address of the first misaligned access since clear
module dm_unit
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 128,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [2:0]  dm_type,
    output logic [31:0] dout,
    output logic [31:0] mmio_out,
    output logic        misalign_err,
    output logic [31:0] err_addr
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      ram [DEPTH_WORDS];
    logic [IDX_W-1:0] ram_idx;
    logic             misaligned;
    logic             err_event;
    logic             sel_mmio;
    logic             status_clr;
    logic             ram_we;
    logic [3:0]       st_be;
    logic [31:0]      st_word;
    logic [31:0]      ld_word;
    logic [31:0]      ld_data;

    logic [31:0] cycle_q, cycle_d;
    logic        misalign_err_q, misalign_err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    assign ram_idx    = addr[IDX_W+1:2];
    assign misaligned = is_misaligned(dm_type, addr[1:0]);
    // Misaligned stores always count; misaligned loads count only for the
    // half types, since a word-type read is not distinguishable from idle.
    assign err_event  = misaligned && (mem_w || is_half(dm_type));
    assign ram_we     = mem_w && !misaligned && !sel_mmio;

    dm_lane_align u_align (
        .addr_lo (addr[1:0]),
        .dm_type (dm_type),
        .st_data (din),
        .ld_word (ld_word),
        .st_be   (st_be),
        .st_word (st_word),
        .ld_data (ld_data)
    );

`ifdef DM_MMIO_EN
    logic [1:0]  mmio_off;
    logic [31:0] mmio_out_q, mmio_out_d;

    assign sel_mmio   = (addr[31:4] == MMIO_BASE[31:4]);
    assign mmio_off   = addr[3:2];
    // Any store to STATUS clears, even a misaligned one; the error update
    // below then re-arms the status so the new error wins.
    assign status_clr = mem_w && sel_mmio && (mmio_off == MMIO_OFF_STATUS);
    assign mmio_out   = mmio_out_q;

    always_comb begin
        mmio_out_d = mmio_out_q;
        if (mem_w && sel_mmio && !misaligned && (mmio_off == MMIO_OFF_OUT)) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) mmio_out_d[i*8 +: 8] = st_word[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) mmio_out_q <= 32'h0;
        else       mmio_out_q <= mmio_out_d;
    end
`else
    logic unused_bits;

    assign sel_mmio    = 1'b0;
    assign status_clr  = 1'b0;
    assign mmio_out    = 32'h0;
    assign unused_bits = ^{addr[31:IDX_W+2], MMIO_BASE};
`endif

    // Read source mux; the lane aligner then extracts and extends.
    always_comb begin
        ld_word = ram[ram_idx];
`ifdef DM_MMIO_EN
        if (sel_mmio) begin
            case (mmio_off)
                MMIO_OFF_OUT:    ld_word = mmio_out_q;
                MMIO_OFF_CYCLE:  ld_word = cycle_q;
                MMIO_OFF_STATUS: ld_word = {16'h0000, err_cnt_q, 7'h00, misalign_err_q};
                default:         ld_word = 32'h0;
            endcase
        end
`endif
    end

    assign dout = misaligned ? 32'h0 : ld_data;

    // RAM has no reset; the rstn gate drops a store caught by reset.
    always_ff @(posedge clk) begin
        if (ram_we && rstn) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) ram[ram_idx][i*8 +: 8] <= st_word[i*8 +: 8];
            end
        end
    end

    always_comb begin
        cycle_d        = cycle_q + 32'd1;
        misalign_err_d = misalign_err_q;
        err_addr_d     = err_addr_q;
        err_cnt_d      = err_cnt_q;
        if (status_clr) begin
            misalign_err_d = 1'b0;
            err_addr_d     = 32'h0;
            err_cnt_d      = 8'h00;
        end
        if (err_event) begin
            if (!misalign_err_d) err_addr_d = addr;
            misalign_err_d = 1'b1;
            if (err_cnt_d != 8'hFF) err_cnt_d = err_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_q        <= 32'h0;
            misalign_err_q <= 1'b0;
            err_addr_q     <= 32'h0;
            err_cnt_q      <= 8'h00;
        end else begin
            cycle_q        <= cycle_d;
            misalign_err_q <= misalign_err_d;
            err_addr_q     <= err_addr_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign misalign_err = misalign_err_q;
    assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_dm_unit.sv
// tb_dm_unit: self-checking bench for dm_unit. Directed vector table,
// hand-written multi-cycle sequences (MMIO, saturation, reset during a
// store) and randomized traffic checked against a byte-addressed model.
// Build with +define+DM_MMIO_EN to exercise the MMIO window.
module tb_dm_unit;

    localparam logic [31:0] BASE      = 32'hFFFF_0000;
    localparam int          RAM_BYTES = 128 * 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] din;
    logic [2:0]  dm_type;
    logic [31:0] dout;
    logic [31:0] mmio_out;
    logic        misalign_err;
    logic [31:0] err_addr;

    dm_unit #(.DEPTH_WORDS(128), .MMIO_BASE(BASE)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .mem_w        (mem_w),
        .addr         (addr),
        .din          (din),
        .dm_type      (dm_type),
        .dout         (dout),
        .mmio_out     (mmio_out),
        .misalign_err (misalign_err),
        .err_addr     (err_addr)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int txn_no  = 0;

    // ---------------- reference model ----------------
    logic [7:0]  m_mem [RAM_BYTES];
    logic        m_err;
    logic [31:0] m_err_addr;
    int          m_cnt;
    logic [31:0] m_out;

    function automatic int size_of(input logic [2:0] t);
        if (t == 3'd1 || t == 3'd2) return 2;
        if (t == 3'd3 || t == 3'd4) return 1;
        return 4;
    endfunction

    function automatic bit m_misaligned(input logic [2:0] t, input logic [31:0] a);
        return (int'(a[1:0]) % size_of(t)) != 0;
    endfunction

    function automatic bit m_is_mmio(input logic [31:0] a);
`ifdef DM_MMIO_EN
        return a[31:4] == BASE[31:4];
`else
        return (a == 32'h0) && (a != 32'h0);
`endif
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        int ba;
        if (m_is_mmio(a)) begin
            case (a[3:2])
                2'd0:    return m_out;
                2'd2:    return {16'h0, 8'(m_cnt), 7'h0, m_err};
                default: return 32'h0;
            endcase
        end
        ba = int'(a % 32'(RAM_BYTES));
        ba = ba - (ba % 4);
        return {m_mem[ba+3], m_mem[ba+2], m_mem[ba+1], m_mem[ba]};
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a);
        logic [31:0] v;
        if (m_misaligned(t, a)) return 32'h0;
        v = m_word(a) >> (8 * int'(a[1:0]));
        if (size_of(t) == 1) begin
            v = v & 32'hFF;
            if (t == 3'd3 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size_of(t) == 2) begin
            v = v & 32'hFFFF;
            if (t == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic void m_commit(input logic w, input logic [2:0] t,
                                     input logic [31:0] a, input logic [31:0] d);
        bit mis = m_misaligned(t, a);
        int sz  = size_of(t);
        bit mm  = m_is_mmio(a);
        if (w && mm && a[3:2] == 2'd2) begin
            m_err = 1'b0; m_err_addr = 32'h0; m_cnt = 0;
        end
        if (w && !mis) begin
            if (mm) begin
                if (a[3:2] == 2'd0)
                    for (int k = 0; k < sz; k++) m_out[8*(int'(a[1:0])+k) +: 8] = d[8*k +: 8];
            end else begin
                for (int k = 0; k < sz; k++) m_mem[int'(a % 32'(RAM_BYTES)) + k] = d[8*k +: 8];
            end
        end
        if (mis && (w || sz == 2)) begin
            if (!m_err) m_err_addr = a;
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
    endfunction

    function automatic void m_reset();
        m_err = 1'b0; m_err_addr = 32'h0; m_cnt = 0; m_out = 32'h0;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %08h expected %08h", name, act, exp);
        else n_pass++;
    endtask

    // One transaction: drive at negedge, sample dout before the commit edge,
    // commit the model at posedge, return at the next negedge.
    task automatic step(input logic w, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] seen, output logic [31:0] exp_d);
        mem_w = w; dm_type = t; addr = a; din = d;
        #1;
        seen  = dout;
        exp_d = m_load(t, a);
        @(posedge clk);
        m_commit(w, t, a, d);
        @(negedge clk);
        mem_w = 1'b0;
        txn_no++;
        $display("txn %0d w=%0b t=%0d a=%08h d=%08h dout=%08h err=%0b", txn_no, w, t, a, d, seen, misalign_err);
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        bit          chk;
        logic [31:0] exp_dout;
        logic        exp_err;
        logic [31:0] exp_eaddr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic w, input logic [2:0] t, input logic [31:0] a,
                                input logic [31:0] d, input bit chk, input logic [31:0] ed,
                                input logic ee, input logic [31:0] ea);
        vec_t v;
        v.w = w; v.t = t; v.a = a; v.d = d; v.chk = chk;
        v.exp_dout = ed; v.exp_err = ee; v.exp_eaddr = ea;
        tbl.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] seen, mexp;
        logic        w;
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        int          r;

        // --- vector table: {w, type, addr, din, check dout, dout, err, err_addr}
        add(1, 3'd0, 32'h10,  32'h1234_5678, 0, 32'h0,         0, 32'h0);
        add(0, 3'd3, 32'h11,  32'h0,         1, 32'h0000_0056, 0, 32'h0);
        add(0, 3'd4, 32'h13,  32'h0,         1, 32'h0000_0012, 0, 32'h0);
        add(0, 3'd1, 32'h12,  32'h0,         1, 32'h0000_1234, 0, 32'h0);
        add(1, 3'd0, 32'h20,  32'h0,         0, 32'h0,         0, 32'h0);
        add(1, 3'd3, 32'h22,  32'h0000_00AB, 0, 32'h0,         0, 32'h0);
        add(0, 3'd0, 32'h20,  32'h0,         1, 32'h00AB_0000, 0, 32'h0);
        add(0, 3'd3, 32'h22,  32'h0,         1, 32'hFFFF_FFAB, 0, 32'h0);
        add(1, 3'd1, 32'h20,  32'h1234_8001, 0, 32'h0,         0, 32'h0);
        add(0, 3'd2, 32'h20,  32'h0,         1, 32'h0000_8001, 0, 32'h0);
        add(0, 3'd1, 32'h20,  32'h0,         1, 32'hFFFF_8001, 0, 32'h0);
        add(0, 3'd0, 32'h20,  32'h0,         1, 32'h00AB_8001, 0, 32'h0);
        add(1, 3'd0, 32'h210, 32'hA5A5_A5A5, 0, 32'h0,         0, 32'h0);
        add(0, 3'd0, 32'h10,  32'h0,         1, 32'hA5A5_A5A5, 0, 32'h0);
        add(1, 3'd0, 32'h30,  32'h0,         0, 32'h0,         0, 32'h0);
        add(1, 3'd0, 32'h4,   32'hDEAD_BEEF, 0, 32'h0,         0, 32'h0);
        add(1, 3'd0, 32'h6,   32'h1,         1, 32'h0,         1, 32'h6);
        add(0, 3'd0, 32'h4,   32'h0,         1, 32'hDEAD_BEEF, 1, 32'h6);
        add(1, 3'd1, 32'h9,   32'h7777,      1, 32'h0,         1, 32'h6);
        add(0, 3'd4, 32'h7,   32'h0,         1, 32'h0000_00DE, 1, 32'h6);
        add(0, 3'd1, 32'h6,   32'h0,         1, 32'hFFFF_DEAD, 1, 32'h6);

        for (int i = 0; i < RAM_BYTES; i++) m_mem[i] = 8'h00;
        m_reset();
        rstn = 1'b0; mem_w = 1'b0; addr = 32'h0; din = 32'h0; dm_type = 3'd0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_err", {31'b0, misalign_err}, 32'h0);
        check("reset_err_addr", err_addr, 32'h0);
        check("reset_mmio_out", mmio_out, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
`ifdef DM_MMIO_EN
        step(0, 3'd0, BASE + 32'h4, 32'h0, seen, mexp);
        check("cycle_after_10", seen, 32'h0000_000A);
`endif

        foreach (tbl[i]) begin
            step(tbl[i].w, tbl[i].t, tbl[i].a, tbl[i].d, seen, mexp);
            if (tbl[i].chk) check($sformatf("vec%0d_dout", i), seen, tbl[i].exp_dout);
            check($sformatf("vec%0d_err", i), {31'b0, misalign_err}, {31'b0, tbl[i].exp_err});
            check($sformatf("vec%0d_err_addr", i), err_addr, tbl[i].exp_eaddr);
        end

`ifdef DM_MMIO_EN
        step(0, 3'd0, BASE + 32'h8, 32'h0, seen, mexp);
        check("status_cnt2", seen, 32'h0000_0201);
        step(1, 3'd0, BASE, 32'hCAFE_F00D, seen, mexp);
        check("mmio_sw", mmio_out, 32'hCAFE_F00D);
        step(1, 3'd3, BASE + 32'h1, 32'h0000_0011, seen, mexp);
        check("mmio_sb", mmio_out, 32'hCAFE_110D);
        step(0, 3'd1, BASE + 32'h2, 32'h0, seen, mexp);
        check("mmio_lh", seen, 32'hFFFF_CAFE);
        step(1, 3'd0, BASE + 32'h4, 32'h1234, seen, mexp);
        step(0, 3'd0, BASE, 32'h0, seen, mexp);
        check("cycle_store_ignored", seen, 32'hCAFE_110D);
        step(0, 3'd0, BASE + 32'hC, 32'h0, seen, mexp);
        check("mmio_rsvd", seen, 32'h0);
        step(1, 3'd0, BASE + 32'h8, 32'h0, seen, mexp);
        step(0, 3'd0, BASE + 32'h8, 32'h0, seen, mexp);
        check("status_cleared", seen, 32'h0);
        check("clear_err", {31'b0, misalign_err}, 32'h0);
        check("clear_err_addr", err_addr, 32'h0);
        step(1, 3'd1, BASE + 32'h9, 32'h0, seen, mexp);
        check("coinc_err", {31'b0, misalign_err}, 32'h1);
        check("coinc_err_addr", err_addr, BASE + 32'h9);
        step(0, 3'd0, BASE + 32'h8, 32'h0, seen, mexp);
        check("coinc_status", seen, 32'h0000_0101);
        for (int i = 0; i < 260; i++) step(1, 3'd1, 32'h1, 32'h0, seen, mexp);
        step(0, 3'd0, BASE + 32'h8, 32'h0, seen, mexp);
        check("status_saturated", seen, 32'h0000_FF01);
        check("sat_err_addr", err_addr, BASE + 32'h9);
        step(1, 3'd0, BASE + 32'h8, 32'h0, seen, mexp);
        step(1, 3'd0, 32'h5, 32'h0, seen, mexp);
`endif

        // Reset asserted while a store is presented: registers clear at
        // once, the store never reaches RAM.
        mem_w = 1'b1; dm_type = 3'd0; addr = 32'h30; din = 32'h55; rstn = 1'b0;
        #1;
        check("rst_async_err", {31'b0, misalign_err}, 32'h0);
        check("rst_async_err_addr", err_addr, 32'h0);
        check("rst_async_mmio", mmio_out, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1; mem_w = 1'b0;
        m_reset();
        step(0, 3'd0, 32'h30, 32'h0, seen, mexp);
        check("rst_store_dropped", seen, 32'h0);

        // Fill RAM so every model byte is known, then random traffic.
        for (int i = 0; i < 128; i++) step(1, 3'd0, 32'(i * 4), $urandom, seen, mexp);
        for (int i = 0; i < 400; i++) begin
            w = 1'($urandom_range(0, 1));
            t = 3'($urandom_range(0, 7));
            a = $urandom & 32'h0000_0FFF;
            d = $urandom;
`ifdef DM_MMIO_EN
            r = int'($urandom_range(0, 9));
            if (r == 0) a = BASE + 32'h8 + $urandom_range(0, 3);
            else if (r == 1) a = BASE + $urandom_range(0, 3);
`else
            r = 0;
`endif
            step(w, t, a, d, seen, mexp);
            check($sformatf("rnd%0d_dout", i), seen, mexp);
            check($sformatf("rnd%0d_err", i), {31'b0, misalign_err}, {31'b0, m_err});
            check($sformatf("rnd%0d_err_addr", i), err_addr, m_err_addr);
            check($sformatf("rnd%0d_mmio", i), mmio_out, m_out);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
